// File: rtl/svm_seq_mac_ctrl_if.sv
// Bundle between the one-vs-one class picker (master) and the
// shared-MAC sequencer (slave): sample, per-round weights/bias, results.
interface svm_seq_mac_ctrl_if #(
  parameter int N_features   = 21,
  parameter int featureWidth = 4,
  parameter int weightWidth  = 8,
  parameter int biasWidth    = 12,
  parameter int nRounds      = 2
);
  localparam int MW =
    featureWidth + 1 + weightWidth + $clog2(N_features);
  localparam int accWidth =
    ((MW > biasWidth) ? MW : biasWidth) + 1;
  localparam int rw =
    ($clog2(nRounds) > 1) ? $clog2(nRounds) : 1;

  logic                                start;
  logic [featureWidth*N_features-1:0]  features;
  logic [weightWidth*N_features-1:0]   weight;
  logic [biasWidth-1:0]                bia;
  logic                                busy;
  logic                                svmready;
  logic                                w_class;
  logic signed [accWidth-1:0]          score;
  logic [rw-1:0]                       round_idx;
  logic                                done;

  modport master (
    output start, features, weight, bia,
    input  busy, svmready, w_class, score, round_idx, done
  );

  modport slave (
    input  start, features, weight, bia,
    output busy, svmready, w_class, score, round_idx, done
  );
endinterface

// File: rtl/svm_seq_mac_ctrl.sv
// Sequencer for the shared SVM MAC: nRounds binary evaluations per sample.
// Build option SVM_SEQ_ZERO_SKIP_EN skips zero-valued features.
module svm_seq_mac_ctrl #(
  parameter int N_features   = 21,
  parameter int featureWidth = 4,
  parameter int weightWidth  = 8,
  parameter int biasWidth    = 12,
  parameter int nRounds      = 2
) (
  input logic               clk,
  input logic               rst,
  svm_seq_mac_ctrl_if.slave bus
);
  localparam int N  = N_features;
  localparam int FW = featureWidth;
  localparam int WW = weightWidth;
  localparam int BW = biasWidth;
  localparam int MW = FW + 1 + WW + $clog2(N);
  localparam int AW = ((MW > BW) ? MW : BW) + 1;
  localparam int RW = ($clog2(nRounds) > 1) ? $clog2(nRounds) : 1;
  localparam int IW = ($clog2(N) > 1) ? $clog2(N) : 1;
  localparam int PW = FW + 1 + WW;

  typedef enum logic [1:0] {IDLE, MAC, BIAS, REPORT} state_t;

  state_t               state_q, state_d;
  logic [FW*N-1:0]      xreg_q, xreg_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic [N-1:0]         mask_q, mask_d;
  logic [RW-1:0]        round_q, round_d;
  logic signed [AW-1:0] score_q, score_d;
  logic                 wcls_q, wcls_d;
  logic                 rdy_q, rdy_d;
  logic                 done_q, done_d;

  logic [N-1:0]         mask_ld;
  logic [N-1:0]         clr;
  logic [IW-1:0]        idx;
  logic [FW-1:0]        xf;
  logic [WW-1:0]        wf;
  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] prod_x, bia_x, sum;
  logic                 last_rnd;

`ifdef SVM_SEQ_ZERO_SKIP_EN
  logic [FW*N-1:0] src;
  always_comb begin
    mask_ld = '0;
    src = (state_q == IDLE) ? bus.features : xreg_q;
    for (int i = 0; i < N; i++)
      mask_ld[i] = |src[i*FW +: FW];
  end
`else
  assign mask_ld = '1;
`endif

  // lowest pending feature is processed first
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (mask_q[i]) idx = IW'(i);
  end

  assign clr    = mask_q & ~(N'(1) << idx);
  assign xf     = xreg_q[idx*FW +: FW];
  assign wf     = bus.weight[idx*WW +: WW];
  assign prod   = $signed({1'b0, xf}) * $signed(wf);
  assign prod_x = {{(AW-PW){prod[PW-1]}}, prod};
  assign bia_x  = {{(AW-BW){bus.bia[BW-1]}}, bus.bia};
  assign sum    = acc_q + bia_x;
  assign last_rnd = (round_q == RW'(nRounds - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (bus.start)
          state_d = (mask_ld != '0) ? MAC : BIAS;
      MAC:
        if (clr == '0) state_d = BIAS;
      BIAS:
        state_d = REPORT;
      REPORT:
        if (last_rnd)              state_d = IDLE;
        else if (mask_ld != '0)    state_d = MAC;
        else                       state_d = BIAS;
      default:
        state_d = IDLE;
    endcase
  end

  always_comb begin
    xreg_d  = xreg_q;
    acc_d   = acc_q;
    mask_d  = mask_q;
    round_d = round_q;
    score_d = score_q;
    wcls_d  = wcls_q;
    rdy_d   = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE:
        if (bus.start) begin
          xreg_d  = bus.features;
          acc_d   = '0;
          round_d = '0;
          mask_d  = mask_ld;
        end
      MAC: begin
        acc_d  = acc_q + prod_x;
        mask_d = clr;
      end
      BIAS: begin
        acc_d   = sum;
        score_d = sum;
        wcls_d  = ~sum[AW-1];
        rdy_d   = 1'b1;
        done_d  = last_rnd;
      end
      REPORT:
        if (!last_rnd) begin
          round_d = round_q + 1'b1;
          acc_d   = '0;
          mask_d  = mask_ld;
        end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xreg_q  <= '0;
      acc_q   <= '0;
      mask_q  <= '0;
      round_q <= '0;
      score_q <= '0;
      wcls_q  <= 1'b0;
      rdy_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      xreg_q  <= xreg_d;
      acc_q   <= acc_d;
      mask_q  <= mask_d;
      round_q <= round_d;
      score_q <= score_d;
      wcls_q  <= wcls_d;
      rdy_q   <= rdy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    bus.busy      = (state_q != IDLE);
    bus.svmready  = rdy_q;
    bus.done      = done_q;
    bus.w_class   = wcls_q;
    bus.score     = score_q;
    bus.round_idx = round_q;
  end
endmodule

// File: tb/tb_svm_seq_mac_ctrl.sv
// Self-checking bench for svm_seq_mac_ctrl (N_features=4, nRounds=2).
// Vector table drives runs; a scoreboard checks every svmready pulse.
module tb_svm_seq_mac_ctrl;
  localparam int N  = 4;
  localparam int FW = 4;
  localparam int WW = 8;
  localparam int BW = 12;
  localparam int NR = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  svm_seq_mac_ctrl_if #(
    .N_features(N), .featureWidth(FW), .weightWidth(WW),
    .biasWidth(BW), .nRounds(NR)
  ) bus ();

  svm_seq_mac_ctrl #(
    .N_features(N), .featureWidth(FW), .weightWidth(WW),
    .biasWidth(BW), .nRounds(NR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    logic [15:0] x;
    logic [31:0] w;
    int b0;
    int b1;
    int s0;
    int s1;
  } vec_t;

  typedef struct {
    int score;
    int rnd;
    int at;
  } exp_t;

  exp_t sbq[$];
  exp_t me;
  vec_t tbl[9];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint got,
                     input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask

  function automatic int model(input logic [15:0] x,
                               input logic [31:0] w, input int b);
    int s = b;
    for (int i = 0; i < N; i++)
      s += int'(x[i*FW +: FW]) * int'($signed(w[i*WW +: WW]));
    return s;
  endfunction

  function automatic int kcnt(input logic [15:0] x);
    int nz = 0;
    for (int i = 0; i < N; i++)
      if (x[i*FW +: FW] != 0) nz++;
`ifdef SVM_SEQ_ZERO_SKIP_EN
    return nz;
`else
    return N;
`endif
  endfunction

  always @(negedge clk) begin
    if (!rst && bus.svmready) begin
      if (sbq.size() == 0) begin
        chk("unexpected_svmready", 1, 0);
      end else begin
        me = sbq.pop_front();
        chk("score", bus.score, me.score);
        chk("w_class", bus.w_class, me.score >= 0);
        chk("round_idx", bus.round_idx, me.rnd);
        chk("ready_cycle", cyc, me.at);
        chk("done", bus.done, me.rnd == NR - 1);
      end
    end
    if (!rst && bus.done && !bus.svmready)
      chk("done_without_ready", 1, 0);
  end

  task automatic run_vec(input vec_t v, input bit hz);
    int  e0;
    int  k;
    bit  seen;
    @(negedge clk);
    bus.features = v.x;
    bus.weight   = v.w;
    bus.bia      = BW'(v.b0);
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    e0 = cyc;
    k  = kcnt(v.x);
    sbq.push_back('{v.s0, 0, e0 + k + 1});
    sbq.push_back('{v.s1, 1, e0 + k + 1 + k + 2});
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.svmready) seen = 1'b1;
      else if (hz && i == 1) begin
        bus.start    = 1'b1;
        bus.features = ~v.x;
      end else if (hz && i == 2) begin
        bus.start    = 1'b0;
        bus.features = v.x;
      end
    end
    bus.start    = 1'b0;
    bus.features = v.x;
    if (!seen) chk("ready0_timeout", 0, 1);
    bus.bia = BW'(v.b1);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    if (!seen) chk("done_timeout", 0, 1);
    chk("busy_at_done", bus.busy, 1);
    @(negedge clk);
    chk("busy_fall", bus.busy, 0);
    chk("busy_fall_cycle", cyc, e0 + NR * (k + 2));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int errs;
    tbl[0] = '{16'h2503, 32'h04FDFF02, -1, 3, -2, 2};
    tbl[1] = '{16'hFFFF, 32'h80808080, -2048, -2048, -9728, -9728};
    tbl[2] = '{16'hFFFF, 32'h7F7F7F7F, 2047, 2047, 9667, 9667};
    tbl[3] = '{16'h0700, 32'h00050000, 0, 0, 35, 35};
    tbl[4] = '{16'h0000, 32'h12345678, 0, 0, 0, 0};
    tbl[5] = '{16'h0A01, 32'hF0107F80, -5, 100, 0, 0};
    for (int i = 6; i < 9; i++) begin
      tbl[i].x  = 16'($urandom);
      tbl[i].w  = $urandom;
      tbl[i].b0 = int'($urandom_range(0, 4095)) - 2048;
      tbl[i].b1 = int'($urandom_range(0, 4095)) - 2048;
    end
    for (int i = 5; i < 9; i++) begin
      tbl[i].s0 = model(tbl[i].x, tbl[i].w, tbl[i].b0);
      tbl[i].s1 = model(tbl[i].x, tbl[i].w, tbl[i].b1);
    end

    rst = 1'b1;
    bus.start    = 1'b0;
    bus.features = '0;
    bus.weight   = '0;
    bus.bia      = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_svmready", bus.svmready, 0);
    chk("rst_w_class", bus.w_class, 0);
    chk("rst_score", bus.score, 0);
    chk("rst_round_idx", bus.round_idx, 0);
    chk("rst_done", bus.done, 0);
    rst = 1'b0;
    errs = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.busy) errs++;
    end
    chk("idle_busy_low", errs, 0);

    for (int i = 0; i < 9; i++) run_vec(tbl[i], 1'b0);

    run_vec(tbl[0], 1'b1);

    @(negedge clk);
    bus.features = tbl[2].x;
    bus.weight   = tbl[2].w;
    bus.bia      = BW'(tbl[2].b0);
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_busy", bus.busy, 1);
    rst = 1'b1;
    #1;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_svmready", bus.svmready, 0);
    chk("midrst_score", bus.score, 0);
    chk("midrst_w_class", bus.w_class, 0);
    @(negedge clk);
    rst = 1'b0;
    errs = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.busy || bus.svmready || bus.done) errs++;
    end
    chk("post_rst_quiet", errs, 0);
    run_vec(tbl[0], 1'b0);

    repeat (3) @(negedge clk);
    chk("sb_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
